// File: rtl/pipelined_adder.sv
// Carry-pipelined adder/subtractor: each stage adds one W-bit slice and registers its
// carry for the next stage, with a valid/ready handshake that stalls the whole pipe.
module pipelined_adder #(
    parameter int BITS   = 8,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            cin,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BITS-1:0] sum,
    output logic            cout,
    output logic            overflow
);
    localparam int W = BITS / STAGES;

    logic              advance;
    logic [STAGES-1:0] vld_q;

    assign advance   = !vld_q[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_q[STAGES-1];

    if (STAGES == 1) begin : g_vld
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
            end else if (advance) begin
                vld_q <= in_valid;
            end
        end
    end else begin : g_vld
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
            end else if (advance) begin
                vld_q <= {vld_q[STAGES-2:0], in_valid};
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * W;

        // Operand bits from this stage's slice upward; lower bits were consumed earlier.
        logic [BITS-LO-1:0] a_in;
        logic [BITS-LO-1:0] b_in;
        logic               sub_s;
        logic               ci_s;
        logic [W-1:0]       bx_s;
        logic [W:0]         add_s;
        logic [LO+W-1:0]    sum_d;
        logic [LO+W-1:0]    sum_q;
        logic               c_q;

        // ---- stage k input: ports for stage 0, skew registers of stage k-1 otherwise
        if (k == 0) begin : g_src
            assign a_in  = a;
            assign b_in  = b;
            assign sub_s = sub;
            assign ci_s  = cin ^ sub;
            assign sum_d = add_s[W-1:0];
        end else begin : g_src
            assign a_in  = g_stage[k-1].g_skew.a_q;
            assign b_in  = g_stage[k-1].g_skew.b_q;
            assign sub_s = g_stage[k-1].g_skew.sub_q;
            assign ci_s  = g_stage[k-1].c_q;
            assign sum_d = {add_s[W-1:0], g_stage[k-1].sum_q};
        end

        assign bx_s  = b_in[W-1:0] ^ {W{sub_s}};
        assign add_s = {1'b0, a_in[W-1:0]} + {1'b0, bx_s} + {{W{1'b0}}, ci_s};

        // ---- stage k register: intermediate stages carry skew and partial sum
        if (k < STAGES - 1) begin : g_skew
            logic [BITS-LO-W-1:0] a_q;
            logic [BITS-LO-W-1:0] b_q;
            logic                 sub_q;

            always_ff @(posedge clk) begin
                if (advance) begin
                    a_q   <= a_in[BITS-LO-1:W];
                    b_q   <= b_in[BITS-LO-1:W];
                    sub_q <= sub_s;
                    c_q   <= add_s[W];
                    sum_q <= sum_d;
                end
            end
        end else begin : g_last
            logic vin;
            logic ovf_q;
            logic carry_msb;

            if (k == 0) begin : g_vin
                assign vin = in_valid;
            end else begin : g_vin
                assign vin = vld_q[k-1];
            end

            // Carry into the MSB recovered from the MSB's own sum bit.
            assign carry_msb = add_s[W-1] ^ a_in[W-1] ^ bx_s[W-1];

            // Output register only loads valid slots so results hold across bubbles.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sum_q <= '0;
                    c_q   <= 1'b0;
                    ovf_q <= 1'b0;
                end else if (advance && vin) begin
                    sum_q <= sum_d;
                    c_q   <= add_s[W];
                    ovf_q <= carry_msb ^ add_s[W];
                end
            end
        end
    end

    assign sum      = g_stage[STAGES-1].sum_q;
    assign cout     = g_stage[STAGES-1].c_q;
    assign overflow = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: three depths (2, 1, 8) on shared inputs, checked against
// an integer-arithmetic reference model and a FIFO scoreboard.
module tb_pipelined_adder;
    localparam int NI = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic out_ready;
    logic cin;
    logic sub;
    logic [7:0] a;
    logic [7:0] b;
    logic [NI-1:0] irdy;
    logic [NI-1:0] ovld;
    logic [NI-1:0] cout_w;
    logic [NI-1:0] ovf_w;
    logic [NI-1:0][7:0] sum_w;

    int checks = 0;
    int failures = 0;
    int stg [NI] = '{2, 1, 8};

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic       sb;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    vec_t vecs [5] = '{
        '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1},
        '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0},
        '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1},
        '{8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0}
    };

    always #5 clk = ~clk;

    pipelined_adder #(.BITS(8), .STAGES(2)) u_s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[0]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ovld[0]), .out_ready(out_ready),
        .sum(sum_w[0]), .cout(cout_w[0]), .overflow(ovf_w[0]));

    pipelined_adder #(.BITS(8), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[1]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ovld[1]), .out_ready(out_ready),
        .sum(sum_w[1]), .cout(cout_w[1]), .overflow(ovf_w[1]));

    pipelined_adder #(.BITS(8), .STAGES(8)) u_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[2]),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ovld[2]), .out_ready(out_ready),
        .sum(sum_w[2]), .cout(cout_w[2]), .overflow(ovf_w[2]));

    // Reference: {overflow, cout, sum} from plain integer arithmetic.
    function automatic logic [9:0] ref_model(input logic [7:0] x, input logic [7:0] y,
                                             input logic ci, input logic sb);
        int ux, uy, sx, sy, c, ures, sres;
        logic [7:0] s8;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 128) ? ux - 256 : ux;
        sy = (uy >= 128) ? uy - 256 : uy;
        c  = int'(ci);
        if (!sb) begin
            ures = ux + uy + c;
            sres = sx + sy + c;
        end else begin
            ures = ux + (255 - uy) + (1 - c);
            sres = sx - sy - c;
        end
        s8 = ures[7:0];
        return {(sres > 127 || sres < -128), (ures >= 256), s8};
    endfunction

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a = 8'hA5; b = 8'h5A; cin = 1'b1; sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (ovld[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_out_valid S=%0d got=%b want=0", stg[i], ovld[i]);
            end
            checks++;
            if ({ovf_w[i], cout_w[i], sum_w[i]} !== 10'h000) begin
                failures++;
                $display("FAIL reset_outputs S=%0d got ovf=%b cout=%b sum=%h want 0/0/00",
                         stg[i], ovf_w[i], cout_w[i], sum_w[i]);
            end
            checks++;
            if (irdy[i] !== 1'b1) begin
                failures++;
                $display("FAIL reset_in_ready S=%0d got=%b want=1", stg[i], irdy[i]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        for (int v = 0; v < 5; v++) begin
            apply_reset();
            a = vecs[v].a; b = vecs[v].b; cin = vecs[v].ci; sub = vecs[v].sb;
            in_valid  = 1'b1;
            out_ready = 1'b1;
            for (int cyc = 1; cyc <= 9; cyc++) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                a = ~vecs[v].a;
                b = ~vecs[v].b;
                @(negedge clk);
                for (int i = 0; i < NI; i++) begin
                    checks++;
                    if (cyc < stg[i]) begin
                        if (ovld[i] !== 1'b0) begin
                            failures++;
                            $display("FAIL directed_early v%0d S=%0d edge%0d got vld=%b want=0",
                                     v, stg[i], cyc, ovld[i]);
                        end
                    end else if ({ovld[i], ovf_w[i], cout_w[i], sum_w[i]} !==
                                 {(cyc == stg[i]), vecs[v].ov, vecs[v].co, vecs[v].s}) begin
                        failures++;
                        $display("FAIL directed v%0d S=%0d edge%0d got vld=%b sum=%h cout=%b ovf=%b want vld=%b sum=%h cout=%b ovf=%b",
                                 v, stg[i], cyc, ovld[i], sum_w[i], cout_w[i], ovf_w[i],
                                 (cyc == stg[i]), vecs[v].s, vecs[v].co, vecs[v].ov);
                    end
                end
            end
        end
    endtask

    task automatic test_stream();
        logic [9:0] q[$];
        logic [9:0] exp;
        int sent = 0;
        int got = 0;
        apply_reset();
        for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
            @(negedge clk);
            out_ready = 1'($urandom_range(0, 1));
            in_valid  = (sent < 16);
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            #1;
            checks++;
            if (irdy[0] !== (!ovld[0] || out_ready)) begin
                failures++;
                $display("FAIL stream_in_ready cyc%0d got=%b want=%b", cyc, irdy[0],
                         (!ovld[0] || out_ready));
            end
            if (ovld[0] && out_ready) begin
                checks++;
                got++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL stream_extra result%0d got sum=%h with nothing outstanding",
                             got, sum_w[0]);
                end else begin
                    exp = q.pop_front();
                    if ({ovf_w[0], cout_w[0], sum_w[0]} !== exp) begin
                        failures++;
                        $display("FAIL stream_result%0d got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                                 got, ovf_w[0], cout_w[0], sum_w[0], exp[9], exp[8], exp[7:0]);
                    end
                end
            end
            if (in_valid && irdy[0]) begin
                q.push_back(ref_model(a, b, cin, sub));
                sent++;
            end
        end
        checks++;
        if (got != 16 || q.size() != 0) begin
            failures++;
            $display("FAIL stream_count got=%0d results, %0d outstanding, want 16 and 0",
                     got, q.size());
        end
    endtask

    task automatic test_stall();
        logic [9:0] q[$];
        logic [9:0] exp;
        logic [10:0] held;
        apply_reset();
        out_ready = 1'b0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            #1;
            if (in_valid && irdy[0]) q.push_back(ref_model(a, b, cin, sub));
        end
        checks++;
        if (q.size() != 2) begin
            failures++;
            $display("FAIL stall_fill accepted=%0d want=2", q.size());
        end
        @(negedge clk);
        #1;
        held = {ovld[0], ovf_w[0], cout_w[0], sum_w[0]};
        checks++;
        if (q.size() == 0 || held !== {1'b1, q[0]}) begin
            failures++;
            $display("FAIL stall_head got=%h want vld=1 with first result", held);
        end
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            in_valid = 1'b1;
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
            #1;
            checks++;
            if ({ovld[0], ovf_w[0], cout_w[0], sum_w[0]} !== held) begin
                failures++;
                $display("FAIL stall_hold cyc%0d got=%h want=%h", cyc,
                         {ovld[0], ovf_w[0], cout_w[0], sum_w[0]}, held);
            end
            checks++;
            if (irdy[0] !== 1'b0) begin
                failures++;
                $display("FAIL stall_in_ready cyc%0d got=%b want=0", cyc, irdy[0]);
            end
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (ovld[0]) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL stall_drain_extra got sum=%h with nothing outstanding", sum_w[0]);
                end else begin
                    exp = q.pop_front();
                    if ({ovf_w[0], cout_w[0], sum_w[0]} !== exp) begin
                        failures++;
                        $display("FAIL stall_drain got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
                                 ovf_w[0], cout_w[0], sum_w[0], exp[9], exp[8], exp[7:0]);
                    end
                end
            end
            @(negedge clk);
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL stall_drain_count outstanding=%0d want=0", q.size());
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        a = 8'h21; b = 8'h43;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        #2;
        checks++;
        if ({ovld[0], sum_w[0]} !== {1'b1, 8'h46}) begin
            failures++;
            $display("FAIL async_pre got vld=%b sum=%h want vld=1 sum=46", ovld[0], sum_w[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ovld[0], ovf_w[0], cout_w[0], sum_w[0]} !== 11'h000) begin
            failures++;
            $display("FAIL async_clear got vld=%b ovf=%b cout=%b sum=%h want all 0",
                     ovld[0], ovf_w[0], cout_w[0], sum_w[0]);
        end
        checks++;
        if (irdy[0] !== 1'b1) begin
            failures++;
            $display("FAIL async_in_ready got=%b want=1", irdy[0]);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(negedge clk);
            #1;
            checks++;
            if (ovld[0] !== 1'b0) begin
                failures++;
                $display("FAIL async_stale cyc%0d got vld=%b sum=%h want vld=0", cyc, ovld[0], sum_w[0]);
            end
        end
        @(negedge clk);
        a = 8'h0F; b = 8'h01; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ovld[0] !== 1'b0) begin
            failures++;
            $display("FAIL async_relat_early got vld=%b want=0", ovld[0]);
        end
        @(negedge clk);
        checks++;
        if ({ovld[0], sum_w[0]} !== {1'b1, 8'h10}) begin
            failures++;
            $display("FAIL async_relat got vld=%b sum=%h want vld=1 sum=10", ovld[0], sum_w[0]);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stream();
        test_stall();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
